// File: rtl/hls_run_pkg.sv
// Shared types for the HLS run sequencer: FSM states, record status codes
// and the per-run result record.
package hls_run_pkg;

  localparam int REC_RUN_W = 8;
  localparam int REC_CYC_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    START,
    WAIT,
    REPORT,
    FIN
  } state_e;

  typedef enum logic [1:0] {
    ST_PASS    = 2'd0,
    ST_FAIL    = 2'd1,
    ST_NOCMP   = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  typedef struct packed {
    logic [REC_RUN_W-1:0] idx;
    status_e              status;
    logic [REC_CYC_W-1:0] cycles;
  } rec_t;

endpackage

// File: rtl/hls_cycle_counter.sv
// Saturating load/increment counter with an equality compare against a limit.
// Shared by the DUT reset hold and the run latency/timeout measurement.
module hls_cycle_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o,
  output logic         eq_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (inc_i && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign eq_o  = (cnt_q == limit_i);

endmodule

// File: rtl/hls_run_sequencer.sv
// Batch run controller for start/done HLS accelerators: resets, starts and
// times each run, then reports one result record per run.
module hls_run_sequencer
  import hls_run_pkg::*;
#(
  parameter int RET_W      = 64,
  parameter int CYC_W      = REC_CYC_W,
  parameter int RUN_W      = REC_RUN_W,
  parameter int RST_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [RUN_W-1:0] num_runs,
  input  logic [CYC_W-1:0] timeout_cycles,
  input  logic             cmp_en,
  input  logic [RET_W-1:0] exp_ret,
  output logic             dut_reset,
  output logic             dut_start,
  input  logic             dut_done,
  input  logic [RET_W-1:0] dut_ret,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [RUN_W-1:0] rec_idx,
  output logic [1:0]       rec_status,
  output logic [CYC_W-1:0] rec_cycles,
  output logic             busy,
  output logic             batch_done,
  output logic [RUN_W-1:0] fail_cnt
);

  state_e           state_q, state_d;
  logic [RUN_W-1:0] nruns_q, idx_q, idx_d, fail_q, fail_d;
  logic [CYC_W-1:0] to_q;
  logic             cmp_q;
  logic [RET_W-1:0] exp_q;
  rec_t             rec_q, rec_d;

  logic             cnt_load, cnt_inc, cnt_eq;
  logic [CYC_W-1:0] cnt, cnt_lim;
  logic             cap;
  status_e          cap_st, done_st;
  logic [CYC_W-1:0] cap_cyc;

  hls_cycle_counter #(.W(CYC_W)) u_cnt (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .inc_i      (cnt_inc),
    .load_val_i (CYC_W'(1)),
    .limit_i    (cnt_lim),
    .cnt_o      (cnt),
    .eq_o       (cnt_eq)
  );

  assign cnt_lim = (state_q == RST) ? CYC_W'(RST_CYCLES) : to_q;
  assign done_st = !cmp_q ? ST_NOCMP :
                   (dut_ret == exp_q) ? ST_PASS : ST_FAIL;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    rec_d   = rec_q;
    cap     = 1'b0;
    cap_st  = ST_PASS;
    cap_cyc = cnt;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          idx_d   = '0;
          fail_d  = '0;
          state_d = (num_runs == '0) ? FIN : RST;
        end
      end
      RST: begin
        if (cnt_eq) state_d = START;
      end
      START: begin
        if (dut_done) begin
          cap    = 1'b1;
          cap_st = done_st;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // done has priority over a timeout landing in the same cycle
        if (dut_done) begin
          cap    = 1'b1;
          cap_st = done_st;
        end else if (to_q != '0 && cnt_eq) begin
          cap     = 1'b1;
          cap_st  = ST_TIMEOUT;
          cap_cyc = to_q;
        end
      end
      REPORT: begin
        if (rec_ready) begin
          if (rec_q.status == ST_TIMEOUT ||
              idx_q == nruns_q - 1'b1) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RST;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (cap) begin
      state_d = REPORT;
      rec_d   = '{idx: idx_q, status: cap_st, cycles: cap_cyc};
      if ((cap_st == ST_FAIL || cap_st == ST_TIMEOUT) && fail_q != '1)
        fail_d = fail_q + 1'b1;
    end
  end

  assign cnt_load = (state_d == RST || state_d == START) &&
                    (state_d != state_q);
  assign cnt_inc  = !cnt_load &&
                    (state_q == RST || state_q == START ||
                     state_q == WAIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      nruns_q <= '0;
      idx_q   <= '0;
      fail_q  <= '0;
      to_q    <= '0;
      cmp_q   <= 1'b0;
      exp_q   <= '0;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      rec_q   <= rec_d;
      if (state_q == IDLE && go) begin
        nruns_q <= num_runs;
        to_q    <= timeout_cycles;
        cmp_q   <= cmp_en;
        exp_q   <= exp_ret;
      end
    end
  end

  assign dut_reset  = (state_q == IDLE) || (state_q == RST);
  assign dut_start  = (state_q == START);
  assign rec_valid  = (state_q == REPORT);
  assign busy       = (state_q != IDLE);
  assign batch_done = (state_q == FIN);
  assign rec_idx    = rec_q.idx;
  assign rec_status = rec_q.status;
  assign rec_cycles = rec_q.cycles;
  assign fail_cnt   = fail_q;

endmodule

// File: doc/hls_run_sequencer.md
Name: hls_run_sequencer

Overview:
- Synthesizable run controller for HLS-generated accelerators with a start/done handshake.
- Runs the DUT for a programmable number of runs. Each run is: reset pulse, one-cycle start, wait for done, then the cycle count is measured and the return value compared.
- Emits one result record per run through a valid/ready port.
- Replaces the per-design simulation sequencer so the same flow runs on FPGA for latency characterisation.

Parameters:
- RET_W, 64, width of DUT return value and expected value.
- CYC_W, 32, width of cycle counter, timeout and record cycle field.
- RUN_W, 8, width of run count and run index.
- RST_CYCLES, 2, cycles dut_reset is held high before each run (minimum 1).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- go  in  1  pulse; starts a batch when idle, ignored otherwise.
- num_runs  in  RUN_W  runs in the batch, sampled on go; 0 means the batch completes immediately.
- timeout_cycles  in  CYC_W  per-run cycle limit, sampled on go; 0 disables the timeout.
- cmp_en  in  1  compare enable, sampled on go.
- exp_ret  in  RET_W  expected return value, sampled on go.
- dut_reset  out  1  active-high reset to the DUT.
- dut_start  out  1  one-cycle start pulse to the DUT.
- dut_done  in  1  DUT completion.
- dut_ret  in  RET_W  DUT return value, valid while dut_done is high.
- rec_valid  out  1  result record valid.
- rec_ready  in  1  consumer accepts the record.
- rec_idx  out  RUN_W  run index of the record.
- rec_status  out  2  record status: 0=PASS, 1=FAIL, 2=NOCMP, 3=TIMEOUT.
- rec_cycles  out  CYC_W  measured run latency.
- busy  out  1  high in every state except IDLE.
- batch_done  out  1  one-cycle pulse at the end of a batch.
- fail_cnt  out  RUN_W  FAIL plus TIMEOUT count for the current batch.

Behaviour:
- Reset values: all outputs 0 except dut_reset=1; state IDLE.
- dut_reset is high in IDLE and RST, and low otherwise.
- IDLE:
  - go=1 latches num_runs, timeout_cycles, cmp_en and exp_ret, and clears run index and fail_cnt.
  - If num_runs=0, go to FIN; otherwise go to RST.
- RST: hold for RST_CYCLES cycles using the reset counter, then go to START.
- START (one cycle):
  - dut_start=1; cycle counter loaded with 1.
  - If dut_done=1 in this cycle, capture immediately with cycles=1.
  - Otherwise go to WAIT.
- WAIT:
  - Counter increments each cycle, saturating at all-ones.
  - dut_done=1 captures rec_cycles = counter value in that cycle (done on the first cycle after start gives 2).
  - Status on done: cmp_en=0 gives NOCMP; otherwise PASS if dut_ret==exp_ret, else FAIL.
  - Timeout: timeout_cycles≠0, counter==timeout_cycles and dut_done=0 gives status TIMEOUT with rec_cycles=timeout_cycles.
  - If done and the timeout fire in the same cycle, done wins.
  - Next state: REPORT.
- REPORT:
  - rec_valid=1; record fields are held stable until rec_valid && rec_ready.
  - On acceptance with status TIMEOUT: go to FIN (the batch aborts and remaining runs are skipped).
  - On acceptance with any other status: if run index == num_runs-1, go to FIN; otherwise increment the index and go to RST.
  - A FAIL or TIMEOUT record increments fail_cnt in the REPORT entry cycle, saturating.
- FIN: batch_done=1 for one cycle, then IDLE. fail_cnt holds until the next go.
- go while busy is ignored. dut_done outside START/WAIT is ignored.
- Synchronous reset mid-batch: return to IDLE and drop any pending record (rec_valid=0 next cycle); dut_reset=1.

Decomposition:
- Package hls_run_pkg holds:
  - the state enum (IDLE, RST, START, WAIT, REPORT, FIN);
  - the status codes (ST_PASS, ST_FAIL, ST_NOCMP, ST_TIMEOUT);
  - a record struct {idx, status, cycles}.
- One sub-module, hls_cycle_counter: saturating load/increment counter with an equality compare against the limit. It is reused for both the RST hold and the WAIT timing.

Test Plan:
- num_runs=3, cmp_en=1, exp_ret=42. DUT model returns 42 and raises done 10 cycles after start.
  → 3 records, idx 0..2, PASS, rec_cycles=11 each; fail_cnt=0; batch_done once; dut_reset high for 2 cycles before each start.
- Same setup but run 1 returns 41.
  → statuses PASS, FAIL, PASS; fail_cnt=1.
- timeout_cycles=5, DUT never raises done, num_runs=4.
  → one record, idx 0, TIMEOUT, cycles=5; batch aborts; batch_done; fail_cnt=1.
- DUT raises done in the start cycle.
  → rec_cycles=1. Separately, timeout_cycles=7 with done on the counter==7 cycle → PASS, cycles=7.
- rec_ready held low for 20 cycles in REPORT.
  → fields stable, no new dut_start. go pulses while busy have no effect; num_runs=0 → batch_done only, no records.
- Assert reset during WAIT of run 2.
  → next cycle: IDLE, rec_valid=0, dut_reset=1, busy=0. A new go restarts from idx 0.
